// File: rtl/tx_gen_crc_pkg.sv
// tx_gen_crc_pkg: CRC-32 constants, FSM state type and a single-byte CRC update shared by the packet generator.
package tx_gen_crc_pkg;
    localparam logic [31:0] CRC32_POLY_R = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT = 32'hFFFFFFFF;
    typedef enum logic {IDLE, SEND} state_t;
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int k = 0; k < 8; k++) c = c[0] ? (c >> 1) ^ CRC32_POLY_R : c >> 1;
        return c;
    endfunction
endpackage

// File: rtl/crc32_bytes.sv
// crc32_bytes: combinational CRC-32 update by 0..NB enabled bytes, lane 0 first.
module crc32_bytes import tx_gen_crc_pkg::*; #(
    parameter int NB = 4
) (
    input  logic [31:0]     crc_in,
    input  logic [8*NB-1:0] data,
    input  logic [NB-1:0]   en,
    output logic [31:0]     crc_out
);
    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < NB; i++) if (en[i]) crc_out = crc32_byte(crc_out, data[8*i +: 8]);
    end
endmodule

// File: rtl/tx_gen_crc.sv
// tx_gen_crc: emits cmd_len counting bytes from cmd_seed followed by their CRC-32 on an AXI-stream.
module tx_gen_crc import tx_gen_crc_pkg::*; #(
    parameter int OEW   = 2,
    parameter int LEN_W = 16
) (
    input  logic                  rstn,
    input  logic                  clk,
    output logic                  cmd_ready,
    input  logic                  cmd_valid,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [7:0]            cmd_seed,
    input  logic                  o_tready,
    output logic                  o_tvalid,
    output logic [(8<<OEW)-1:0]   o_tdata,
    output logic [(1<<OEW)-1:0]   o_tkeep,
    output logic                  o_tlast,
    output logic                  busy
);
    localparam int B  = 1 << OEW;
    localparam int CW = LEN_W + 3;
    state_t state, state_d;
    logic [LEN_W-1:0] len_q;
    logic [7:0]       seed_q, src_seed;
    logic [CW-1:0]    cnt_q, src_cnt, src_len;
    logic [31:0]      crc_q, src_crc, crc_new, crc_fin;
    logic [8*B-1:0]   pay_data, beat;
    logic [B-1:0]     pay_en, keep_d;
    logic [2*B-1:0]   off;
    logic             accept, load, done, last_d;

    assign accept  = cmd_valid && cmd_ready;
    assign done    = o_tvalid && o_tready && o_tlast;
    assign load    = accept || (state == SEND && o_tvalid && o_tready && !o_tlast);
    assign busy    = state == SEND;
    // The beat is built from the incoming command on the acceptance cycle so it is valid one cycle later
    assign src_cnt  = accept ? '0 : cnt_q;
    assign src_len  = CW'(accept ? cmd_len : len_q);
    assign src_seed = accept ? cmd_seed : seed_q;
    assign src_crc  = accept ? CRC32_INIT : crc_q;
    assign last_d   = src_cnt + CW'(B) >= src_len + CW'(4);
    assign crc_fin  = crc_new ^ CRC32_XOROUT;

    always_comb begin
        pay_data = '0;
        pay_en   = '0;
        keep_d   = '0;
        off      = '0;
        for (int j = 0; j < B; j++) begin
            pay_en[j]          = src_cnt + CW'(j) < src_len;
            keep_d[j]          = src_cnt + CW'(j) < src_len + CW'(4);
            pay_data[8*j +: 8] = src_seed + src_cnt[7:0] + 8'(j);
            off[2*j +: 2]      = 2'(src_cnt + CW'(j) - src_len);
        end
    end

    crc32_bytes #(.NB(B)) u_crc (
        .crc_in (src_crc),
        .data   (pay_data),
        .en     (pay_en),
        .crc_out(crc_new)
    );

    // CRC lanes use the CRC already including this beat's payload bytes
    always_comb begin
        beat = '0;
        for (int j = 0; j < B; j++)
            beat[8*j +: 8] = !keep_d[j] ? 8'h00 : pay_en[j] ? pay_data[8*j +: 8] : crc_fin[{off[2*j +: 2], 3'b000} +: 8];
    end

    always_comb state_d = state == IDLE ? (accept ? SEND : IDLE) : (done ? IDLE : SEND);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            o_tvalid  <= 1'b0;
            o_tdata   <= '0;
            o_tkeep   <= '0;
            o_tlast   <= 1'b0;
            len_q     <= '0;
            seed_q    <= '0;
            cnt_q     <= '0;
            crc_q     <= CRC32_INIT;
        end else begin
            state     <= state_d;
            cmd_ready <= state_d == IDLE;
            if (accept) begin
                len_q  <= cmd_len;
                seed_q <= cmd_seed;
            end
            if (load) begin
                o_tvalid <= 1'b1;
                o_tdata  <= beat;
                o_tkeep  <= keep_d;
                o_tlast  <= last_d;
                cnt_q    <= src_cnt + CW'(B);
                crc_q    <= crc_new;
            end else if (done) begin
                o_tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_tx_gen_crc.sv
// tb_tx_gen_crc: checks 8/16/32-bit instances of tx_gen_crc against a byte-list CRC-32 packet model.
module tb_tx_gen_crc;
    logic        clk = 1'b0, rstn = 1'b0;
    logic [15:0] cmd_len = '0;
    logic [7:0]  cmd_seed = '0;
    logic [2:0]  cv = '0, rdy = '0, cr, tv, tl, bz;
    logic [7:0]  td0;
    logic [15:0] td1;
    logic [31:0] td2;
    logic [0:0]  tk0;
    logic [1:0]  tk1;
    logic [3:0]  tk2;
    logic [31:0] got_d[$], exp_d[$];
    logic [3:0]  got_k[$], exp_k[$];
    bit          got_l[$], exp_l[$];
    int          errors = 0, checks = 0, unstable = 0;

    always #5 clk = ~clk;

    tx_gen_crc #(.OEW(0), .LEN_W(16)) u0 (.rstn(rstn), .clk(clk), .cmd_ready(cr[0]), .cmd_valid(cv[0]),
        .cmd_len(cmd_len), .cmd_seed(cmd_seed), .o_tready(rdy[0]), .o_tvalid(tv[0]), .o_tdata(td0),
        .o_tkeep(tk0), .o_tlast(tl[0]), .busy(bz[0]));
    tx_gen_crc #(.OEW(1), .LEN_W(16)) u1 (.rstn(rstn), .clk(clk), .cmd_ready(cr[1]), .cmd_valid(cv[1]),
        .cmd_len(cmd_len), .cmd_seed(cmd_seed), .o_tready(rdy[1]), .o_tvalid(tv[1]), .o_tdata(td1),
        .o_tkeep(tk1), .o_tlast(tl[1]), .busy(bz[1]));
    tx_gen_crc #(.OEW(2), .LEN_W(16)) u2 (.rstn(rstn), .clk(clk), .cmd_ready(cr[2]), .cmd_valid(cv[2]),
        .cmd_len(cmd_len), .cmd_seed(cmd_seed), .o_tready(rdy[2]), .o_tvalid(tv[2]), .o_tdata(td2),
        .o_tkeep(tk2), .o_tlast(tl[2]), .busy(bz[2]));

    function automatic logic [31:0] cur_d(input int u);
        return u == 0 ? {24'd0, td0} : u == 1 ? {16'd0, td1} : td2;
    endfunction

    function automatic logic [3:0] cur_k(input int u);
        return u == 0 ? {3'd0, tk0} : u == 1 ? {2'd0, tk1} : tk2;
    endfunction

    // Reference: list the whole byte stream (payload + CRC LE), then cut it into beats of 1<<u bytes
    task automatic build_exp(input int u, input int len, input logic [7:0] seed);
        logic [7:0]  m[$];
        logic [31:0] crc, w;
        logic [3:0]  kp;
        logic [7:0]  by;
        int          b;
        b = 1 << u;
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < len; i++) begin
            by = seed + 8'(i);
            m.push_back(by);
            crc = crc ^ {24'd0, by};
            for (int k = 0; k < 8; k++) crc = crc[0] ? (crc >> 1) ^ 32'hEDB88320 : crc >> 1;
        end
        crc = ~crc;
        for (int i = 0; i < 4; i++) m.push_back(crc[8*i +: 8]);
        exp_d.delete(); exp_k.delete(); exp_l.delete();
        for (int k = 0; k * b < m.size(); k++) begin
            w = '0;
            kp = '0;
            for (int j = 0; j < b; j++)
                if (k * b + j < m.size()) begin
                    w[8*j +: 8] = m[k*b+j];
                    kp[j] = 1'b1;
                end
            exp_d.push_back(w);
            exp_k.push_back(kp);
            exp_l.push_back(k * b + b >= m.size());
        end
    endtask

    function automatic int first_diff();
        int n = got_d.size() < exp_d.size() ? got_d.size() : exp_d.size();
        for (int k = 0; k < n; k++)
            if (got_d[k] !== exp_d[k] || got_k[k] !== exp_k[k] || got_l[k] !== exp_l[k]) return k;
        return got_d.size() == exp_d.size() ? -1 : n;
    endfunction

    function automatic string diff_str(input int k);
        if (k < got_d.size() && k < exp_d.size())
            return $sformatf("beat %0d got data=%h keep=%h last=%0d, exp data=%h keep=%h last=%0d",
                k, got_d[k], got_k[k], got_l[k], exp_d[k], exp_k[k], exp_l[k]);
        return $sformatf("beat count got %0d exp %0d", got_d.size(), exp_d.size());
    endfunction

    // Called at a negedge; returns at the negedge following the accepting posedge
    task automatic issue(input int u, input int len, input logic [7:0] seed, output bit to);
        to = 1'b1;
        cmd_len = 16'(len);
        cmd_seed = seed;
        cv[u] = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (cr[u]) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        cv[u] = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the tlast handshake
    task automatic collect(input int u, input int pct, output bit to);
        logic [31:0] pd;
        logic [3:0]  pk;
        bit          pl, hold, r, fin;
        hold = 1'b0;
        to = 1'b1;
        unstable = 0;
        got_d.delete(); got_k.delete(); got_l.delete();
        for (int n = 0; n < 400; n++) begin
            if (hold && (!tv[u] || cur_d(u) !== pd || cur_k(u) !== pk || tl[u] !== pl)) unstable++;
            r = $urandom_range(99) < pct;
            rdy[u] = r;
            pd = cur_d(u);
            pk = cur_k(u);
            pl = tl[u];
            hold = tv[u] && !r;
            fin = tv[u] && r && tl[u];
            if (tv[u] && r) begin
                got_d.push_back(pd);
                got_k.push_back(pk);
                got_l.push_back(pl);
            end
            @(negedge clk);
            if (fin) begin
                to = 1'b0;
                break;
            end
        end
        rdy[u] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({cr, tv, tl, bz} !== 12'd0) begin
            errors++;
            $display("FAIL reset_ctrl: ready=%b valid=%b last=%b busy=%b, want all 0", cr, tv, tl, bz);
        end
        checks++;
        if ({td0, td1, td2, tk0, tk1, tk2} !== 63'd0) begin
            errors++;
            $display("FAIL reset_data: data=%h/%h/%h keep=%h/%h/%h, want 0", td0, td1, td2, tk0, tk1, tk2);
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if (cr !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready_rise: ready=%b, want 111", cr);
        end
    endtask

    task automatic test_basic();
        logic [31:0] sd[4];
        logic [3:0]  sk[4];
        bit          to;
        int          bad;
        sd = '{32'h34333231, 32'h38373635, 32'hF4392639, 32'h000000CB};
        sk = '{4'hF, 4'hF, 4'hF, 4'h1};
        issue(2, 9, 8'h31, to);
        checks++;
        if (to || tv[2] !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency: accept_timeout=%0d valid=%b, want 0 and 1", to, tv[2]);
        end
        collect(2, 100, to);
        bad = -1;
        for (int k = 0; k < 4; k++)
            if (bad < 0 && (k >= got_d.size() || got_d[k] !== sd[k] || got_k[k] !== sk[k] || got_l[k] !== (k == 3))) bad = k;
        checks++;
        if (to || got_d.size() != 4 || bad >= 0) begin
            errors++;
            $display("FAIL basic_beats: timeout=%0d beats=%0d first bad beat %0d, want 4 beats 34333231 38373635 F4392639 000000CB", to, got_d.size(), bad);
        end
        checks++;
        if (bz[2] !== 1'b0 || tv[2] !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: busy=%b valid=%b, want 0 0", bz[2], tv[2]);
        end
    endtask

    task automatic test_pkt(input string name, input int u, input int len, input logic [7:0] seed, input int pct);
        bit to1, to2;
        int d;
        issue(u, len, seed, to1);
        collect(u, pct, to2);
        build_exp(u, len, seed);
        d = first_diff();
        checks++;
        if (to1 || to2 || d >= 0) begin
            errors++;
            $display("FAIL %s: timeout=%0d/%0d %s", name, to1, to2, d >= 0 ? diff_str(d) : "");
        end
        checks++;
        if (unstable != 0 || bz[u] !== 1'b0) begin
            errors++;
            $display("FAIL %s_stall: unstable=%0d busy=%b, want 0 0", name, unstable, bz[u]);
        end
    endtask

    task automatic test_wrap();
        test_pkt("wrap", 1, 3, 8'hFE, 100);
        checks++;
        if (got_d.size() < 2 || got_d[0][15:0] !== 16'hFFFE || got_k[1] !== 4'h3) begin
            errors++;
            $display("FAIL wrap_bytes: beat0=%h, want 0000FFFE", got_d.size() > 0 ? got_d[0] : 32'hx);
        end
    endtask

    task automatic test_hold_valid();
        logic [7:0] seed;
        bit         to, ok;
        int         d;
        seed = 8'($urandom);
        build_exp(2, 5, seed);
        cmd_len = 16'd5;
        cmd_seed = seed;
        cv[2] = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (cr[2]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        for (int p = 0; p < 2; p++) begin
            checks++;
            if (!ok || tv[2] !== 1'b1) begin
                errors++;
                $display("FAIL hold_accept%0d: accepted=%0d valid=%b, want 1 1", p, ok, tv[2]);
            end
            collect(2, 100, to);
            d = first_diff();
            checks++;
            if (to || d >= 0) begin
                errors++;
                $display("FAIL hold_pkt%0d: timeout=%0d %s", p, to, d >= 0 ? diff_str(d) : "");
            end
            checks++;
            if (tv[2] !== 1'b0 || cr[2] !== 1'b1) begin
                errors++;
                $display("FAIL hold_idle%0d: valid=%b ready=%b, want 0 1", p, tv[2], cr[2]);
            end
            if (p == 0) @(negedge clk);
        end
        cv[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (tv[2] !== 1'b0 || bz[2] !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: valid=%b busy=%b, want 0 0", tv[2], bz[2]);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        int spur;
        issue(2, 9, 8'h31, to);
        rdy[2] = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        rdy[2] = 1'b1;
        @(negedge clk);
        checks++;
        if (to || tv[2] !== 1'b0 || tl[2] !== 1'b0 || bz[2] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: timeout=%0d valid=%b last=%b busy=%b, want 0 0 0 0", to, tv[2], tl[2], bz[2]);
        end
        rstn = 1'b1;
        spur = 0;
        repeat (4) begin
            @(negedge clk);
            if (tv[2] || tl[2]) spur++;
        end
        rdy[2] = 1'b0;
        checks++;
        if (spur != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: %0d cycles with valid/last after reset, want 0", spur);
        end
        test_pkt("reset_mid_after", 2, 9, 8'h31, 100);
    endtask

    task automatic test_random();
        for (int i = 0; i < 12; i++)
            test_pkt($sformatf("random%0d", i), $urandom_range(2), $urandom_range(20), 8'($urandom), $urandom_range(100, 30));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pkt("empty", 0, 0, 8'h5A, 100);
        test_wrap();
        test_pkt("stall", 2, 9, 8'h31, 50);
        test_hold_valid();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
